// File: rtl/c_buffer_drain.sv
// Streams M*ceil(N/4) words out of global buffer C onto a valid/ready port.
// Define C_DRAIN_PERF_EN to build the stall_cnt back-pressure counter.
module c_buffer_drain #(
   parameter int unsigned ADDR_BITS = 16,
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned C_BASE    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           M,
   input  logic [7:0]           N,
   output logic                 busy,
   output logic                 done,
   output logic                 C_wr_en,
   output logic [ADDR_BITS-1:0] C_index,
   input  logic [DATA_BITS-1:0] C_data_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_last,
   output logic [15:0]          stall_cnt
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StCalc  = 3'd1;
   localparam logic [2:0] StRead  = 3'd2;
   localparam logic [2:0] StDrain = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   localparam logic [ADDR_BITS-1:0] BaseAddr = ADDR_BITS'(C_BASE);

   logic [2:0]           state_q, state_d;
   logic [7:0]           m_q, n_q;
   logic [15:0]          w_q, w_calc;
   logic [15:0]          issue_idx_q;
   logic [ADDR_BITS-1:0] c_index_q;
   logic                 inflight_q, inflight_last_q;
   logic [DATA_BITS-1:0] fifo_data_q [2];
   logic                 fifo_last_q [2];
   logic                 wr_ptr_q, rd_ptr_q;
   logic [1:0]           count_q;

   logic pop, issue, last_issue, has_room, drain_done;

   always_comb begin
      pop        = (count_q != 2'd0) && out_ready;
      w_calc     = 16'(m_q) * 16'((9'(n_q) + 9'd3) >> 2);
      last_issue = (issue_idx_q == w_q - 16'd1);
      // A beat leaving this cycle frees a slot, which keeps 1 word/cycle with only 2 entries.
      has_room   = ({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
      issue      = (state_q == StRead) && (issue_idx_q != w_q) && has_room;
      drain_done = !inflight_q && ((count_q == 2'd0) || (count_q == 2'd1 && pop));

      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StCalc;
         StCalc:  state_d = (w_calc == 16'd0) ? StDone : StRead;
         StRead:  if (issue && last_issue) state_d = StDrain;
         StDrain: if (drain_done) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         m_q             <= 8'd0;
         n_q             <= 8'd0;
         w_q             <= 16'd0;
         issue_idx_q     <= 16'd0;
         c_index_q       <= BaseAddr;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q[0]  <= '0;
         fifo_data_q[1]  <= '0;
         fifo_last_q[0]  <= 1'b0;
         fifo_last_q[1]  <= 1'b0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= 2'd0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && start) begin
            m_q <= M;
            n_q <= N;
         end
         if (state_q == StCalc) begin
            w_q         <= w_calc;
            issue_idx_q <= 16'd0;
            c_index_q   <= BaseAddr;
         end
         // C_index holds the address being read; it stays on the final address once issued.
         if (issue) begin
            issue_idx_q <= issue_idx_q + 16'd1;
            if (!last_issue) c_index_q <= c_index_q + ADDR_BITS'(1);
         end
         inflight_q      <= issue;
         inflight_last_q <= issue && last_issue;
         if (inflight_q) begin
            fifo_data_q[wr_ptr_q] <= C_data_out;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         case ({inflight_q, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      C_wr_en   = 1'b0;
      C_index   = c_index_q;
      out_valid = (count_q != 2'd0);
      out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
      out_last  = out_valid && fifo_last_q[rd_ptr_q];
   end

`ifdef C_DRAIN_PERF_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 16'd0;
      end else if (state_q == StIdle && start) begin
         stall_q <= 16'd0;
      end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_c_buffer_drain.sv
// Scoreboard bench for c_buffer_drain: directed transfers, back-pressure, reset and address wrap.
module tb_c_buffer_drain;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [7:0]  M, N;
   logic        busy, done, c_wr_en, out_valid, out_last;
   logic        out_ready = 1'b0;
   logic [15:0] c_index, stall_cnt;
   logic [31:0] c_data_out, out_data;

   logic        w_start;
   logic        w_busy, w_done, w_wr_en, w_valid, w_last;
   logic        w_ready = 1'b1;
   logic [15:0] w_index, w_stall;
   logic [31:0] w_data_out, w_data;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    first_beat_cyc = -1;
   int    last_beat_cyc = -1;
   int    stalls = 0;
   int    rmode = 0;
   int    rphase = 0;
   logic  prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   beat_t exp_q[$];

   always #5 clk = ~clk;

   c_buffer_drain #(.ADDR_BITS(16), .DATA_BITS(32), .C_BASE(0)) dut (
      .clk(clk), .rst(rst), .start(start), .M(M), .N(N), .busy(busy), .done(done),
      .C_wr_en(c_wr_en), .C_index(c_index), .C_data_out(c_data_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .stall_cnt(stall_cnt)
   );

   c_buffer_drain #(.ADDR_BITS(16), .DATA_BITS(32), .C_BASE(32'h0000_FFFE)) dut_wrap (
      .clk(clk), .rst(rst), .start(w_start), .M(8'd1), .N(8'd16), .busy(w_busy),
      .done(w_done), .C_wr_en(w_wr_en), .C_index(w_index), .C_data_out(w_data_out),
      .out_valid(w_valid), .out_ready(w_ready), .out_data(w_data), .out_last(w_last),
      .stall_cnt(w_stall)
   );

   function automatic logic [31:0] word(input logic [15:0] a);
      return 32'hA500_0000 | {16'h0000, a};
   endfunction

   // Synchronous-read SRAM models.
   always @(posedge clk) begin
      c_data_out <= word(c_index);
      w_data_out <= word(w_index);
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #3;
         rphase++;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rphase % 3 == 1);
            2:       out_ready = (rphase > 20);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each accepted beat.
   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         chk("wr_en_zero", {31'd0, c_wr_en}, 32'd0);
         if (prev_stall) begin
            chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
            chk("stall_data_held", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat actual=%h required=none", out_data);
            end else begin
               b = exp_q.pop_front();
               chk("beat_data", out_data, b.data);
               chk("beat_last", {31'd0, out_last}, {31'd0, b.last});
            end
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
         end
         if (out_valid && !out_ready) stalls++;
         if (done) begin
            chk("done_nothing_pending", exp_q.size(), 32'd0);
            if (last_beat_cyc >= 0) chk("done_after_last", cyc, last_beat_cyc + 1);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic do_start(input logic [7:0] m, input logic [7:0] n, input int w);
      beat_t b;
      @(posedge clk);
      #1;
      start = 1'b1;
      M = m;
      N = n;
      first_beat_cyc = -1;
      last_beat_cyc = -1;
      stalls = 0;
      rphase = 0;
      for (int i = 0; i < w; i++) begin
         b.data = word(16'(i));
         b.last = (i == w - 1);
         exp_q.push_back(b);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max);
      logic seen;
      seen = 1'b0;
      repeat (max) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk(name, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      logic [15:0] seq[$];
      logic [15:0] addr;
      int          k;
      logic        seen;

      rst = 1'b1;
      start = 1'b0;
      M = 8'd0;
      N = 8'd0;
      w_start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_wr_en", {31'd0, c_wr_en}, 32'd0);
      chk("rst_index", {16'd0, c_index}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
      chk("rst_wrap_index", {16'd0, w_index}, 32'h0000_FFFE);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: full-rate transfer, M=4 N=4 -> 4 words
      rmode = 0;
      do_start(8'd4, 8'd4, 4);
      wait_done("t1_done_seen", 60);
      chk("t1_consecutive", last_beat_cyc - first_beat_cyc, 32'd3);
      chk("t1_drained", exp_q.size(), 32'd0);

      // 2: ready pattern 1,0,0 with M=2 N=5 -> 4 words
      rmode = 1;
      do_start(8'd2, 8'd5, 4);
      wait_done("t2_done_seen", 80);
      chk("t2_drained", exp_q.size(), 32'd0);
`ifdef C_DRAIN_PERF_EN
      chk("t2_stall_cnt", {16'd0, stall_cnt}, stalls);
`else
      chk("t2_stall_cnt_tied", {16'd0, stall_cnt}, 32'd0);
`endif

      // 3: M=0 -> CALC then DONE, no beats
      rmode = 0;
      do_start(8'd0, 8'd7, 0);
      @(negedge clk);
      chk("t3_busy_calc", {31'd0, busy}, 32'd1);
      chk("t3_done_calc", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("t3_busy_done", {31'd0, busy}, 32'd1);
      chk("t3_done_pulse", {31'd0, done}, 32'd1);
      chk("t3_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("t3_busy_idle", {31'd0, busy}, 32'd0);
      chk("t3_done_low", {31'd0, done}, 32'd0);

      // 4: 20-cycle stall, M=3 N=8 -> 6 words
      rmode = 2;
      do_start(8'd3, 8'd8, 6);
      repeat (14) @(negedge clk);
      chk("t4_valid_held", {31'd0, out_valid}, 32'd1);
      chk("t4_reads_bounded", {31'd0, (c_index <= 16'd2)}, 32'd1);
      wait_done("t4_done_seen", 120);
      chk("t4_drained", exp_q.size(), 32'd0);

      // 5a: start during READ is ignored, M=2 N=12 -> 6 words
      rmode = 1;
      do_start(8'd2, 8'd12, 6);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      M = 8'd8;
      N = 8'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("t5_done_seen", 120);
      chk("t5_drained", exp_q.size(), 32'd0);

      // 5b: reset while in DRAIN with words held
      rmode = 3;
      do_start(8'd1, 8'd5, 2);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("t5_pre_busy", {31'd0, busy}, 32'd1);
      chk("t5_pre_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_rst_data", out_data, 32'd0);
      chk("t5_rst_last", {31'd0, out_last}, 32'd0);
      chk("t5_rst_index", {16'd0, c_index}, 32'd0);
      chk("t5_rst_stall", {16'd0, stall_cnt}, 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("t5_no_done", {31'd0, done}, 32'd0);
      end
      rmode = 0;

      // 6: C_BASE=FFFE, W=4 -> address wrap
      @(posedge clk);
      #1;
      w_start = 1'b1;
      @(posedge clk);
      #1;
      w_start = 1'b0;
      seq.push_back(w_index);
      k = 0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (w_index != seq[seq.size() - 1]) seq.push_back(w_index);
         if (w_valid) begin
            addr = 16'hFFFE + 16'(k);
            chk("t6_beat_data", w_data, word(addr));
            chk("t6_beat_last", {31'd0, w_last}, {31'd0, (k == 3)});
            k++;
         end
         if (w_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("t6_done_seen", {31'd0, seen}, 32'd1);
      chk("t6_beats", k, 32'd4);
      chk("t6_addr_count", seq.size(), 32'd4);
      if (seq.size() == 4) begin
         chk("t6_addr0", {16'd0, seq[0]}, 32'h0000_FFFE);
         chk("t6_addr1", {16'd0, seq[1]}, 32'h0000_FFFF);
         chk("t6_addr2", {16'd0, seq[2]}, 32'h0000_0000);
         chk("t6_addr3", {16'd0, seq[3]}, 32'h0000_0001);
      end
      chk("t6_wr_en", {31'd0, w_wr_en}, 32'd0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
